// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle fetch/execute controller for the 16-register bus datapath
module datapath_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [23:0] imem_data,
  input  logic [15:0] bus,
  output logic [23:0] func,
  output logic [15:0] address,
  output logic [18:0] reg_sig,
  output logic [18:0] tri_sig,
  output logic        busy,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [2:0] {IDLE, FETCH, EX1, EX2, EX3, HALTED} state_t;
  localparam logic [3:0] OP_LDI  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_LDPC = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [18:0] SEL_G   = 19'h10000;
  localparam logic [18:0] SEL_A   = 19'h20000;
  localparam logic [18:0] SEL_IMM = 19'h20000;
  localparam logic [18:0] SEL_PC  = 19'h40000;
  state_t      r_state, w_next;
  logic [15:0] r_pc;
  logic [23:0] r_ir;
  logic        r_illegal;
  logic [3:0]  w_op, w_rx, w_ry;
  logic        w_alu, w_bad;
  logic [18:0] w_rx_oh, w_ry_oh;
  assign w_op    = r_ir[23:20];
  assign w_rx    = r_ir[19:16];
  assign w_ry    = r_ir[15:12];
  assign w_alu   = (w_op >= 4'h2) && (w_op <= 4'h7);
  assign w_bad   = (w_op >= 4'hA) && (w_op <= 4'hE);
  assign w_rx_oh = 19'(1) << w_rx;
  assign w_ry_oh = 19'(1) << w_ry;
  assign imem_req  = (r_state == FETCH);
  assign imem_addr = r_pc;
  assign address   = r_pc;
  assign func      = r_ir;
  assign busy      = (r_state != IDLE) && (r_state != HALTED);
  assign halted    = (r_state == HALTED);
  assign illegal   = r_illegal;
  // state, PC, IR and sticky illegal flag; reset beats start and any late ack
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == FETCH && imem_ack) begin
        r_ir <= imem_data;
        r_pc <= r_pc + 16'd1;
      end
      if (r_state == EX1 && w_op == OP_JMP) r_pc <= bus;
      if (r_state == EX1 && w_bad) r_illegal <= 1'b1;
    end
  end
  // next-state sequencing; only ALU ops walk through EX2/EX3
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, HALTED: w_next = start ? FETCH : r_state;
      FETCH:        w_next = imem_ack ? EX1 : FETCH;
      EX1:          w_next = w_alu ? EX2 : (w_op == OP_HALT) ? HALTED : FETCH;
      EX2:          w_next = EX3;
      EX3:          w_next = FETCH;
      default:      w_next = IDLE;
    endcase
  end
  // Moore decode of register loads and the single bus driver for this cycle
  always_comb begin
    reg_sig = '0;
    tri_sig = '0;
    if (r_state == EX1) begin
      if (w_op == OP_LDI) begin
        tri_sig = SEL_IMM;
        reg_sig = w_rx_oh;
      end else if (w_op == OP_MOV) begin
        tri_sig = w_ry_oh;
        reg_sig = w_rx_oh;
      end else if (w_alu) begin
        tri_sig = w_rx_oh;
        reg_sig = SEL_A;
      end else if (w_op == OP_LDPC) begin
        tri_sig = SEL_PC;
        reg_sig = w_rx_oh;
      end else if (w_op == OP_JMP) begin
        tri_sig = w_rx_oh;
      end
    end else if (r_state == EX2) begin
      tri_sig = w_ry_oh;
      reg_sig = SEL_G;
    end else if (r_state == EX3) begin
      tri_sig = SEL_G;
      reg_sig = w_rx_oh;
    end
  end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed vector table plus hand sequences for datapath_ctrl
module tb_datapath_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, imem_ack;
  logic [23:0] imem_data;
  logic [15:0] bus;
  logic        imem_req, busy, halted, illegal;
  logic [15:0] imem_addr, address;
  logic [23:0] func;
  logic [18:0] reg_sig, tri_sig;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic        rst, st, ack;
    logic [23:0] data;
    logic [15:0] bus;
    logic        req;
    logic [15:0] addr;
    logic [18:0] rs, ts;
    logic [23:0] fn;
    logic        bz, hl, il;
  } vec_t;
  vec_t tbl[$];
  datapath_ctrl #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .bus(bus), .func(func), .address(address), .reg_sig(reg_sig), .tri_sig(tri_sig),
    .busy(busy), .halted(halted), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic v(input logic r, s, a, input logic [23:0] d, input logic [15:0] b,
                   input logic q, input logic [15:0] ad, input logic [18:0] rs, ts,
                   input logic [23:0] fn, input logic bz, hl, il);
    vec_t e;
    e.rst = r; e.st = s; e.ack = a; e.data = d; e.bus = b;
    e.req = q; e.addr = ad; e.rs = rs; e.ts = ts; e.fn = fn; e.bz = bz; e.hl = hl; e.il = il;
    tbl.push_back(e);
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // rst st ack data bus | req addr reg_sig tri_sig func busy halted illegal
    v(1'b1,1'b0,1'b0,24'h000000,16'h0000, 1'b0,16'h0000,19'h00000,19'h00000,24'h000000,1'b0,1'b0,1'b0); // reset
    v(1'b0,1'b1,1'b0,24'h000000,16'h0000, 1'b1,16'h0000,19'h00000,19'h00000,24'h000000,1'b1,1'b0,1'b0); // start
    v(1'b0,1'b0,1'b1,24'h031234,16'h0000, 1'b0,16'h0001,19'h00008,19'h20000,24'h031234,1'b1,1'b0,1'b0); // LDI R3
    v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b1,16'h0001,19'h00000,19'h00000,24'h031234,1'b1,1'b0,1'b0);
    v(1'b0,1'b0,1'b1,24'h212000,16'h0000, 1'b0,16'h0002,19'h20000,19'h00002,24'h212000,1'b1,1'b0,1'b0); // ALU EX1
    v(1'b0,1'b1,1'b0,24'h000000,16'h0000, 1'b0,16'h0002,19'h10000,19'h00004,24'h212000,1'b1,1'b0,1'b0); // EX2, start ignored
    v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b0,16'h0002,19'h00002,19'h10000,24'h212000,1'b1,1'b0,1'b0); // EX3
    v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b1,16'h0002,19'h00000,19'h00000,24'h212000,1'b1,1'b0,1'b0); // FETCH
    for (int i = 0; i < 4; i++)
      v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b1,16'h0002,19'h00000,19'h00000,24'h212000,1'b1,1'b0,1'b0); // stall
    v(1'b0,1'b0,1'b1,24'h940000,16'h0000, 1'b0,16'h0003,19'h00000,19'h00010,24'h940000,1'b1,1'b0,1'b0); // JMP R4
    v(1'b0,1'b0,1'b0,24'h000000,16'hFFFF, 1'b1,16'hFFFF,19'h00000,19'h00000,24'h940000,1'b1,1'b0,1'b0); // PC<-bus
    v(1'b0,1'b0,1'b1,24'h850000,16'h0000, 1'b0,16'h0000,19'h00020,19'h40000,24'h850000,1'b1,1'b0,1'b0); // LDPC R5, wrap
    v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b1,16'h0000,19'h00000,19'h00000,24'h850000,1'b1,1'b0,1'b0);
    v(1'b0,1'b0,1'b1,24'hA00000,16'h0000, 1'b0,16'h0001,19'h00000,19'h00000,24'hA00000,1'b1,1'b0,1'b0); // illegal EX1
    v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b1,16'h0001,19'h00000,19'h00000,24'hA00000,1'b1,1'b0,1'b1); // sticky set
    v(1'b0,1'b0,1'b1,24'hF00000,16'h0000, 1'b0,16'h0002,19'h00000,19'h00000,24'hF00000,1'b1,1'b0,1'b1); // HALT EX1
    v(1'b0,1'b0,1'b1,24'h031234,16'h0000, 1'b0,16'h0002,19'h00000,19'h00000,24'hF00000,1'b0,1'b1,1'b1); // HALTED, ack ignored
    v(1'b0,1'b0,1'b1,24'h031234,16'h0000, 1'b0,16'h0002,19'h00000,19'h00000,24'hF00000,1'b0,1'b1,1'b1);
    v(1'b0,1'b1,1'b0,24'h000000,16'h0000, 1'b1,16'h0002,19'h00000,19'h00000,24'hF00000,1'b1,1'b0,1'b1); // resume
    v(1'b0,1'b0,1'b1,24'h101000,16'h0000, 1'b0,16'h0003,19'h00001,19'h00002,24'h101000,1'b1,1'b0,1'b1); // MOV R0<-R1
    v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b1,16'h0003,19'h00000,19'h00000,24'h101000,1'b1,1'b0,1'b1);
    v(1'b0,1'b0,1'b1,24'h233000,16'h0000, 1'b0,16'h0004,19'h20000,19'h00008,24'h233000,1'b1,1'b0,1'b1); // ALU Rx=Ry
    v(1'b0,1'b0,1'b0,24'h000000,16'h0000, 1'b0,16'h0004,19'h10000,19'h00008,24'h233000,1'b1,1'b0,1'b1); // EX2
    v(1'b1,1'b0,1'b0,24'h000000,16'h0000, 1'b0,16'h0000,19'h00000,19'h00000,24'h000000,1'b0,1'b0,1'b0); // reset mid-EX2
    v(1'b1,1'b1,1'b0,24'h000000,16'h0000, 1'b0,16'h0000,19'h00000,19'h00000,24'h000000,1'b0,1'b0,1'b0); // reset beats start
    v(1'b0,1'b1,1'b0,24'h000000,16'h0000, 1'b1,16'h0000,19'h00000,19'h00000,24'h000000,1'b1,1'b0,1'b0);
    v(1'b1,1'b0,1'b1,24'h031234,16'h0000, 1'b0,16'h0000,19'h00000,19'h00000,24'h000000,1'b0,1'b0,1'b0); // reset mid-FETCH
    v(1'b0,1'b0,1'b1,24'h031234,16'h0000, 1'b0,16'h0000,19'h00000,19'h00000,24'h000000,1'b0,1'b0,1'b0); // late ack
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = '0; bus = '0;
    #2;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; start = tbl[i].st; imem_ack = tbl[i].ack;
      imem_data = tbl[i].data; bus = tbl[i].bus;
      step();
      n_cmp++;
      if ({imem_req, imem_addr, reg_sig, tri_sig, func, busy, halted, illegal} !==
          {tbl[i].req, tbl[i].addr, tbl[i].rs, tbl[i].ts, tbl[i].fn, tbl[i].bz, tbl[i].hl, tbl[i].il}) begin
        n_bad++;
        $display("FAIL vec%0d: got req=%b addr=%h reg=%h tri=%h func=%h busy=%b halt=%b ill=%b expected req=%b addr=%h reg=%h tri=%h func=%h busy=%b halt=%b ill=%b",
                 i, imem_req, imem_addr, reg_sig, tri_sig, func, busy, halted, illegal,
                 tbl[i].req, tbl[i].addr, tbl[i].rs, tbl[i].ts, tbl[i].fn, tbl[i].bz, tbl[i].hl, tbl[i].il);
      end
      if (address !== imem_addr) chk($sformatf("address_eq_pc%0d", i), 32'(address), 32'(imem_addr));
      else n_cmp++;
    end
    reset = 1'b0; imem_ack = 1'b0;
    // hand sequence: delayed-ack fetch of an ALU op, then count execute cycles
    start = 1'b1;
    step();
    start = 1'b0;
    chk("seq_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("seq_stall_addr", 32'(imem_addr), 32'h0000);
      chk("seq_stall_en", 32'({reg_sig, tri_sig}), 32'd0);
    end
    imem_ack = 1'b1; imem_data = 24'h5AB000;
    step();
    imem_ack = 1'b0;
    chk("seq_ex1_tri", 32'(tri_sig), 32'h00400);
    begin
      int cyc = 1;
      while (!imem_req && cyc < 10) begin
        chk("seq_onehot", 32'($countones(tri_sig) <= 1), 32'd1);
        chk("seq_reg18", 32'(reg_sig[18]), 32'd0);
        step();
        if (!imem_req) cyc++;
      end
      chk("seq_alu_cycles", 32'(cyc), 32'd3);
      chk("seq_pc_after", 32'(imem_addr), 32'h0001);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/datapath_ctrl.md
# datapath_ctrl

Multi-cycle control unit for the 16-register bus datapath. It fetches 24-bit instruction words over a request/acknowledge port and holds each one as `func`. It then sequences the datapath register enables (`reg_sig`) and tristate enables (`tri_sig`) through up to three execute cycles per instruction. It also owns the 16-bit program counter, which it drives on `address`.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- start  input  1  one-cycle pulse; leaves IDLE or HALTED and begins fetching.
- imem_req  output  1  fetch request, held high until acknowledged.
- imem_addr  output  16  fetch address (= PC).
- imem_ack  input  1  instruction word valid this cycle.
- imem_data  input  24  instruction word.
- bus  input  16  datapath bus readback, used by JMP.
- func  output  24  latched instruction word (IR) to datapath.
- address  output  16  PC value to datapath PC tristate.
- reg_sig  output  19  datapath register load enables; [15:0] R0–R15, [16] G, [17] A, [18] unused (always 0).
- tri_sig  output  19  bus tristate enables; [15:0] R0–R15, [16] G, [17] immediate, [18] PC.
- busy  output  1  high in any state except IDLE and HALTED.
- halted  output  1  high in HALTED.
- illegal  output  1  sticky flag: an undefined opcode was executed.

## Operation
- Instruction fields:
  - op = IR[23:20], also the ALU function.
  - Rx = IR[19:16].
  - Ry = IR[15:12].
  - imm = IR[15:0].
- Opcodes:
  - 0000 LDI: Rx ← imm.
  - 0001 MOV: Rx ← Ry.
  - 0010–0111 ALU ops: Rx ← Rx op Ry.
  - 1000 LDPC: Rx ← PC.
  - 1001 JMP: PC ← Rx.
  - 1111 HALT.
  - 1010–1110 illegal.
- FSM states: IDLE, FETCH, EX1, EX2, EX3, HALTED.
- Outputs are decoded from the state register and IR only (Moore).
- `tri_sig` is at most one-hot in every cycle.
- **IDLE:** all enables 0. `start` → FETCH.
- **FETCH:** `imem_req`=1 and `imem_addr`=PC.
  - On `imem_ack`: IR ← `imem_data`, PC ← PC+1 (FFFF wraps to 0000), next state EX1.
  - Without `imem_ack`: stay in FETCH.
  - `imem_ack` outside FETCH is ignored.
- **LDI, EX1:** `tri_sig[17]`, `reg_sig[Rx]`, then → FETCH.
- **MOV, EX1:** `tri_sig[Ry]`, `reg_sig[Rx]`, then → FETCH. Rx=Ry is legal and leaves the register unchanged.
- **ALU ops:**
  - EX1: `tri_sig[Rx]`, `reg_sig[17]` (A ← Rx).
  - EX2: `tri_sig[Ry]`, `reg_sig[16]` (G ← ALU(A, bus)).
  - EX3: `tri_sig[16]`, `reg_sig[Rx]`, then → FETCH.
  - The controller never relies on A or G contents across instructions.
- **LDPC, EX1:** `tri_sig[18]`, `reg_sig[Rx]`. The value loaded is the already-incremented PC (address of the next instruction).
- **JMP, EX1:** `tri_sig[Rx]`; PC ← `bus` at the end of EX1; then → FETCH.
- **HALT, EX1:** no enables; → HALTED. In HALTED, `start` → FETCH at the current PC.
- **Illegal, EX1:** no enables; `illegal` ← 1; → FETCH.
- `func` holds IR from the fetch-ack edge until the next fetch-ack. IR is 0 after reset.
- `address` = PC at all times.

## Timing
- Reset values:
  - state IDLE, PC = RESET_PC, IR = 0.
  - `func`=0, `reg_sig`=0, `tri_sig`=0.
  - `imem_req`=0, `busy`=0, `halted`=0, `illegal`=0.
- Reset asserted in any state, including mid-FETCH or EX2: the state above holds from the next edge. A pending fetch is abandoned and a late `imem_ack` is ignored.
- Cycles per instruction, excluding fetch wait:
  - 1 fetch-ack cycle.
  - LDI, MOV, LDPC, JMP, HALT, illegal: 1 execute cycle.
  - ALU ops: 3 execute cycles.
- With zero-wait memory (`imem_ack` high in the first FETCH cycle): LDI takes 2 cycles, ALU ops take 4.
- Enables are valid for the whole state cycle; the datapath captures on the edge that ends the state.
- `start` while busy is ignored.
- `start` and `reset` in the same cycle: reset wins.

## Test plan
- **Reset:** assert `reset` mid-EX2 of an ADD → next cycle all outputs are 0, PC=0000, state IDLE, `imem_req`=0.
- **LDI:** `start`; `imem_data`=0x031234 acked in the first FETCH cycle → next cycle `tri_sig`=0x20000, `reg_sig`=0x00008, `func`=0x031234; R3 reads 0x1234; PC=0001.
- **ALU op:** R1=5, R2=3, instruction 0x212000 → three execute cycles with `tri_sig` = 0x00002 / 0x00004 / 0x10000 and `reg_sig` = 0x20000 / 0x10000 / 0x00002; R1 = ALU(0010, 5, 3).
- **Fetch stall:** hold `imem_ack` low for 4 cycles → `imem_req` stays 1 with a stable `imem_addr`, and all enables stay 0.
- **Branching:**
  - R4=0xFFFF, JMP 0x940000 → PC=FFFF.
  - Next fetch acked → PC wraps to 0000.
  - LDPC R5 (0x850000) fetched at address 0x0000 → R5=0x0001.
- **HALT and illegal:**
  - Opcode 0xA → `illegal`=1 and no enables asserted.
  - HALT 0xF00000 → `halted`=1, `busy`=0.
  - `start` → fetch resumes at the next PC; `illegal` stays 1.
